// File: rtl/instr_fetch_if.sv
// instr_fetch_if: connection between the fetch stage, its instruction ROM
// and the decode stage.
//
// Handshake: instr_valid_o means instr_o/instr_pc_o hold an instruction that
// decode has not taken yet. A transfer happens on a rising edge where
// instr_valid_o && instr_ready_i are both high. While valid is high and ready
// is low, the producer holds instr_o/instr_pc_o stable. A redirect_i pulse
// cancels whatever is on the output in that cycle, even if ready is high.
// The producer never looks at ready before raising valid.
//
// ROM side: rom_data_i is combinational from rom_addr_o in the same cycle.
interface instr_fetch_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
);
  logic              start_i;
  logic [ADDR_W-1:0] rom_addr_o;
  logic [DATA_W-1:0] rom_data_i;
  logic [DATA_W-1:0] instr_o;
  logic [ADDR_W-1:0] instr_pc_o;
  logic              instr_valid_o;
  logic              instr_ready_i;
  logic              redirect_i;
  logic [ADDR_W-1:0] redirect_pc_i;
  logic              halted_o;

  // Fetch stage side.
  modport master (
    input  start_i,
    output rom_addr_o,
    input  rom_data_i,
    output instr_o,
    output instr_pc_o,
    output instr_valid_o,
    input  instr_ready_i,
    input  redirect_i,
    input  redirect_pc_i,
    output halted_o
  );

  // Environment side: control, ROM model and decode.
  modport slave (
    output start_i,
    input  rom_addr_o,
    output rom_data_i,
    input  instr_o,
    input  instr_pc_o,
    input  instr_valid_o,
    output instr_ready_i,
    output redirect_i,
    output redirect_pc_i,
    input  halted_o
  );
endinterface

// File: rtl/instr_fetch.sv
// instr_fetch: program counter and fetch stage in front of a combinational
// 1024x32 instruction ROM. The PC drives the ROM address directly. The ROM
// word is captured into an output register, and decode takes it through a
// valid/ready handshake. Branch/jump redirects flush the output register
// and reload the PC.
//
// Optional feature macro: FETCH_HALT_EN. When it is defined, fetching
// HALT_WORD parks the FSM in HALT. Only a redirect or reset leaves HALT.
// When it is not defined, HALT_WORD is an ordinary instruction and halted_o
// stays 0.
//
// Debug outputs:
//   state_dbg_o     : FSM state (0 = IDLE, 1 = RUN, 2 = HALT).
//   halt_word_dbg_o : the ROM word at the current PC equals HALT_WORD.
module instr_fetch #(
  parameter int                 ADDR_W    = 10,
  parameter int                 DATA_W    = 32,
  parameter logic [ADDR_W-1:0]  RESET_PC  = '0,
  parameter logic [DATA_W-1:0]  HALT_WORD = 32'hFFFF_FFFF
) (
  input  logic               clk,
  input  logic               rst_n,
  instr_fetch_if.master      fif,
  output logic [1:0]         state_dbg_o,
  output logic               halt_word_dbg_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] pc;
  logic [DATA_W-1:0] instr_q;
  logic [ADDR_W-1:0] instr_pc_q;
  logic              valid_q;
  logic              halted_q;

  logic              fetch;
  logic              consume;
  logic              word_is_halt;
  logic              halt_hit;

  // A new word is loaded only in RUN, only when the output slot is free or
  // is being emptied, and never in a redirect cycle.
  assign fetch   = (state == S_RUN) && (!valid_q || fif.instr_ready_i) && !fif.redirect_i;
  assign consume = valid_q && fif.instr_ready_i;

  assign word_is_halt = (fif.rom_data_i == HALT_WORD);

`ifdef FETCH_HALT_EN
  assign halt_hit = word_is_halt;
`else
  // HALT cannot be reached. halted_q stays at its reset value of 0.
  assign halt_hit = 1'b0;
`endif

  // Sequencer: PC, FSM state and output register. Every output is a flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      pc         <= RESET_PC;
      instr_q    <= '0;
      instr_pc_q <= '0;
      valid_q    <= 1'b0;
      halted_q   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          // A redirect here only presets the PC. Fetching starts on start_i.
          if (fif.redirect_i) begin
            pc <= fif.redirect_pc_i;
          end
          if (fif.start_i) begin
            state <= S_RUN;
          end
          if (consume) begin
            valid_q <= 1'b0;
          end
        end

        S_RUN: begin
          if (fif.redirect_i) begin
            // Redirect wins over fetch. The in-flight instruction is dropped.
            pc      <= fif.redirect_pc_i;
            valid_q <= 1'b0;
          end else if (fetch) begin
            instr_q    <= fif.rom_data_i;
            instr_pc_q <= pc;
            valid_q    <= 1'b1;
            if (halt_hit) begin
              // Keep the PC on the halt word so the stopped address is visible.
              state    <= S_HALT;
              halted_q <= 1'b1;
            end else begin
              pc <= pc + ADDR_W'(1);
            end
          end
          // Otherwise valid && !ready: everything holds.
        end

        S_HALT: begin
          if (fif.redirect_i) begin
            pc       <= fif.redirect_pc_i;
            valid_q  <= 1'b0;
            state    <= S_RUN;
            halted_q <= 1'b0;
          end else if (consume) begin
            // The halt word is still handed to decode. After that the slot empties.
            valid_q <= 1'b0;
          end
        end

        default: begin
          state    <= S_IDLE;
          valid_q  <= 1'b0;
          halted_q <= 1'b0;
        end
      endcase
    end
  end

  assign fif.rom_addr_o    = pc;
  assign fif.instr_o       = instr_q;
  assign fif.instr_pc_o    = instr_pc_q;
  assign fif.instr_valid_o = valid_q;
  assign fif.halted_o      = halted_q;

  assign state_dbg_o     = state;
  assign halt_word_dbg_o = word_is_halt;

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
- Program-counter and instruction-fetch stage sitting directly upstream of the 1024x32 instruction ROM.
- Drives the ROM word address and captures the combinational ROM read data into an output instruction register.
- Presents captured instructions to decode with a valid/ready handshake.
- Supports branch/jump redirect with flush, and a halt state.

Parameters:
- ADDR_W, 10, PC / ROM word-address width (1024 words).
- DATA_W, 32, instruction width.
- RESET_PC, 0, PC value loaded on reset.
- HALT_WORD, 32'hFFFF_FFFF, instruction encoding treated as halt (used only with FETCH_HALT_EN).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- start_i  in  1  one-cycle pulse; leaves IDLE and begins fetching.
- rom_addr_o  out  ADDR_W  word address to ROM; equals current PC.
- rom_data_i  in  DATA_W  ROM read data; combinational from rom_addr_o, valid same cycle.
- instr_o  out  DATA_W  captured instruction.
- instr_pc_o  out  ADDR_W  address instr_o was fetched from.
- instr_valid_o  out  1  instr_o/instr_pc_o hold an unconsumed instruction.
- instr_ready_i  in  1  decode accepts instruction this cycle.
- redirect_i  in  1  branch/jump taken; flush and reload PC.
- redirect_pc_i  in  ADDR_W  redirect target.
- halted_o  out  1  FSM in HALT.

Behaviour:
- Reset (asynchronous, rst_n low):
  - pc=RESET_PC, state=IDLE, instr_valid_o=0, instr_o=0, instr_pc_o=0, halted_o=0.
  - rom_addr_o=RESET_PC during reset.
- States IDLE, RUN, HALT; halted_o=1 only in HALT (registered).
- IDLE:
  - No fetch.
  - start_i -> RUN next cycle.
  - redirect_i in IDLE loads pc only; state stays IDLE.
- RUN, fetch condition: fetch = (!instr_valid_o || instr_ready_i) && !redirect_i.
  - On fetch: instr_o<=rom_data_i, instr_pc_o<=pc, instr_valid_o<=1, pc<=pc+1.
  - PC wraps 1023->0 (modulo 2**ADDR_W, no error).
  - Latency: instruction at pc appears on instr_o one clock after rom_addr_o=pc.
  - Sustained throughput: 1 instruction/cycle while instr_ready_i=1.
- Backpressure:
  - valid && !ready: instr_o, instr_pc_o, pc all hold; instr_valid_o stays 1.
  - Outputs never change while valid && !ready (except on redirect).
- Consume without refill: valid && ready in a cycle with no fetch (state not RUN) -> instr_valid_o<=0.
- Redirect (any state except IDLE):
  - pc<=redirect_pc_i and instr_valid_o<=0 at the same edge, regardless of instr_ready_i (in-flight instruction dropped).
  - The first instruction from the target is valid one cycle later.
  - Redirect has priority over fetch.
  - Redirect in HALT -> RUN.
- Simultaneous start_i and redirect_i in IDLE: pc<=redirect_pc_i and state->RUN.
- Reset mid-operation: immediate asynchronous return to reset values; any pending instruction is lost.
- No combinational path from instr_ready_i or redirect_i to any output except through registers.
- rom_addr_o is driven by the pc register only.

Optional Feature:
- Macro: FETCH_HALT_EN.
- Defined:
  - A fetch whose rom_data_i==HALT_WORD still captures the word, with instr_valid_o=1 so decode sees it.
  - State -> HALT at that edge; pc does not increment (stays at the halt word's address).
  - In HALT: no further fetch; the held instruction remains until accepted; halted_o=1 from the next cycle.
  - Exit only via redirect_i or reset.
- Undefined:
  - HALT_WORD is fetched as an ordinary instruction.
  - HALT is unreachable; halted_o is tied 0.

Test Plan:
- Reset then start_i, ROM[0..3]=A0,A1,A2,A3, ready=1 -> instr_o=A0,A1,A2,A3 on consecutive cycles; instr_pc_o=0,1,2,3; rom_addr_o leads instr_pc_o by 1.
- Backpressure: ready=0 for 3 cycles after A1 becomes valid -> instr_o=A1, instr_pc_o=1, rom_addr_o=2 held; after ready=1, A2 follows with no duplicate or skip.
- Redirect: redirect_i=1, redirect_pc_i=10'h200 while A2 valid and ready=0 -> next cycle instr_valid_o=0; following cycle instr_o=ROM[0x200], instr_pc_o=0x200.
- Wrap: redirect to 10'h3FE, ready=1 -> instr_pc_o sequence 0x3FE, 0x3FF, 0x000, 0x001.
- FETCH_HALT_EN, ROM[5]=32'hFFFF_FFFF -> instr_o=FFFF_FFFF at instr_pc_o=5, then halted_o=1 and rom_addr_o stays 5 for 10 cycles; redirect to 0 -> halted_o=0 and fetching resumes at 0. Without the macro, fetch continues to address 6.
- Async reset: assert rst_n=0 mid-stream between clock edges -> instr_valid_o=0 and rom_addr_o=RESET_PC immediately; with no start_i after release, no fetch occurs.
